// File: rtl/boruss_load_store_unit_if.sv
// boruss_load_store_unit_if: request/response handshake and data-port bus of the load/store unit
interface boruss_load_store_unit_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic       req_space;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic       resp_err;
  logic [7:0] mem_address;
  logic [7:0] mem_data_in;
  logic       mem_write_enable;
  logic       mem_read_enable;
  logic       mem_map_select;
  logic [7:0] mem_data_out;
  modport master (
    input  req_valid, req_write, req_space, req_addr, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_address, mem_data_in, mem_write_enable, mem_read_enable, mem_map_select
  );
  modport slave (
    output req_valid, req_write, req_space, req_addr, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_address, mem_data_in, mem_write_enable, mem_read_enable, mem_map_select
  );
endinterface

// File: rtl/boruss_load_store_unit.sv
// boruss_load_store_unit: serialised load/store access to the data memory controller
// BORUSS_LSU_ROM_WRITE_TRAP_EN: ROM stores are refused with resp_err instead of strobed
module boruss_load_store_unit #(
  parameter int READ_LATENCY = 1
) (
  input logic clk,
  input logic reset,
  boruss_load_store_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  state_t     state, state_d;
  logic [3:0] cnt, cnt_d;
  logic       write_q, space_q, trap;
  logic [7:0] addr_q, wdata_q, rdata_q;
`ifdef BORUSS_LSU_ROM_WRITE_TRAP_EN
  logic err_q;
  assign trap = bus.req_write & ~bus.req_space;
  always_ff @(posedge clk or negedge reset)
    if (!reset) err_q <= 1'b0;
    else if (state == IDLE && bus.req_valid) err_q <= trap;
  assign bus.resp_err = (state == RESP) & err_q;
`else
  assign trap = 1'b0;
  assign bus.resp_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      write_q <= 1'b0;
      space_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (state == IDLE && bus.req_valid) begin
        write_q <= bus.req_write;
        space_q <= bus.req_space;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state == WAIT && cnt == '0) rdata_q <= bus.mem_data_out;
    end
  // the wait counter only runs for loads; it reaches 0 in the cycle mem_data_out is valid
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    state_d = state == IDLE   ? (bus.req_valid ? (trap ? RESP : ACCESS) : IDLE) :
              state == ACCESS ? (write_q ? RESP : WAIT) :
              state == WAIT   ? (cnt == '0 ? RESP : WAIT) : IDLE;
    cnt_d   = (state == ACCESS && !write_q) ? 4'(READ_LATENCY - 1) :
              (state == WAIT && cnt != '0) ? cnt - 4'd1 : cnt;
  end
  assign bus.req_ready        = state == IDLE;
  assign bus.resp_valid       = state == RESP;
  assign bus.resp_rdata       = rdata_q;
  assign bus.mem_address      = addr_q;
  assign bus.mem_data_in      = wdata_q;
  assign bus.mem_map_select   = space_q;
  assign bus.mem_write_enable = (state == ACCESS) & write_q;
  assign bus.mem_read_enable  = (state == ACCESS) & ~write_q;
endmodule

// File: tb/tb_boruss_load_store_unit.sv
// tb_boruss_load_store_unit: directed vectors, latency-4 corner cases, random back-to-back traffic
module tb_boruss_load_store_unit;
`ifdef BORUSS_LSU_ROM_WRITE_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam int NR = 40;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0, errors = 0;
  boruss_load_store_unit_if b1();
  boruss_load_store_unit_if b4();
  boruss_load_store_unit #(.READ_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  boruss_load_store_unit #(.READ_LATENCY(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // memory controller model for the latency-1 unit: data valid the cycle after the read strobe
  logic [7:0] cm [2][256];
  bit       pend, pm;
  bit [7:0] pa;
  always @(negedge clk) begin
    b1.mem_data_out = pend ? cm[pm][pa] : 8'($urandom);
    if (b1.mem_write_enable && b1.mem_map_select) cm[1][b1.mem_address] = b1.mem_data_in;
    pend = b1.mem_read_enable;
    pa = b1.mem_address;
    pm = b1.mem_map_select;
  end
  task automatic txn(input logic w, input logic s, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] e, input string tag);
    bit tr = TRAP && w && !s;
    chk({tag, ".ready"}, b1.req_ready, 1);
    b1.req_write = w; b1.req_space = s; b1.req_addr = a; b1.req_wdata = d; b1.req_valid = 1'b1;
    step;
    b1.req_valid = 1'b0;
    if (!tr) begin
      chk({tag, ".strobe"}, {b1.mem_write_enable, b1.mem_read_enable, b1.resp_valid}, {w, ~w, 1'b0});
      chk({tag, ".addr"}, {b1.mem_address, b1.mem_map_select}, {a, s});
      if (w) chk({tag, ".wdata"}, b1.mem_data_in, d);
      if (!w) begin
        step;
        chk({tag, ".wait"}, {b1.mem_write_enable, b1.mem_read_enable, b1.resp_valid}, 3'b000);
      end
      step;
    end
    chk({tag, ".resp"}, {b1.resp_valid, b1.resp_err, b1.mem_write_enable, b1.mem_read_enable},
        {1'b1, tr, 2'b00});
    chk({tag, ".rdata"}, b1.resp_rdata, e);
    step;
    chk({tag, ".idle"}, {b1.resp_valid, b1.req_ready}, 2'b01);
  endtask
  typedef struct packed {logic w; logic s; logic [7:0] a; logic [7:0] d; logic [7:0] e;} vec_t;
  typedef struct {logic w; logic s; logic t; logic [7:0] a; logic [7:0] d; logic [7:0] e; int gap;} rq_t;
  vec_t vt [10];
  rq_t  rq [NR];
  logic [7:0] rm [2][256];
  initial begin
    int n, cyc, last;
    bit seen;
    logic [7:0] hold;
    for (int i = 0; i < 256; i++) begin
      cm[0][i] = 8'(i) ^ 8'h5A; cm[1][i] = 8'h00;
      rm[0][i] = 8'(i) ^ 8'h5A; rm[1][i] = 8'h00;
    end
    vt[0] = {1'b1, 1'b1, 8'h10, 8'hA5, 8'h00};
    vt[1] = {1'b0, 1'b1, 8'h10, 8'h00, 8'hA5};
    vt[2] = {1'b1, 1'b1, 8'h20, 8'h3C, 8'hA5};
    vt[3] = {1'b0, 1'b1, 8'h20, 8'h00, 8'h3C};
    vt[4] = {1'b1, 1'b0, 8'h10, 8'hFF, 8'h3C};
    vt[5] = {1'b0, 1'b0, 8'h10, 8'h00, 8'h4A};
    vt[6] = {1'b0, 1'b1, 8'hFF, 8'h00, 8'h00};
    vt[7] = {1'b1, 1'b1, 8'hFF, 8'h01, 8'h00};
    vt[8] = {1'b0, 1'b1, 8'hFF, 8'h00, 8'h01};
    vt[9] = {1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
    {b1.req_valid, b1.req_write, b1.req_space, b1.req_addr, b1.req_wdata} = '0;
    {b4.req_valid, b4.req_write, b4.req_space, b4.req_addr, b4.req_wdata, b4.mem_data_out} = '0;
    step; step;
    reset = 1'b1;
    step;
    chk("rst.b1.ctl", {b1.req_ready, b1.resp_valid, b1.resp_err, b1.mem_write_enable,
        b1.mem_read_enable, b1.mem_map_select}, 6'b100000);
    chk("rst.b1.data", {b1.resp_rdata, b1.mem_address, b1.mem_data_in}, 24'h0);
    chk("rst.b4.ctl", {b4.req_ready, b4.resp_valid, b4.resp_err, b4.mem_write_enable,
        b4.mem_read_enable, b4.mem_map_select}, 6'b100000);
    chk("rst.b4.data", {b4.resp_rdata, b4.mem_address, b4.mem_data_in}, 24'h0);
    for (int i = 0; i < 10; i++) begin
      txn(vt[i].w, vt[i].s, vt[i].a, vt[i].d, vt[i].e, $sformatf("vec%0d", i));
      if (vt[i].w && vt[i].s) rm[1][vt[i].a] = vt[i].d;
    end
    // latency 4: only the value present in the final wait cycle may be captured
    chk("rl4.ready", b4.req_ready, 1);
    b4.req_write = 1'b0; b4.req_space = 1'b1; b4.req_addr = 8'h33; b4.req_valid = 1'b1;
    step;
    b4.req_valid = 1'b0;
    chk("rl4.strobe", {b4.mem_write_enable, b4.mem_read_enable, b4.resp_valid}, 3'b010);
    for (int i = 2; i <= 5; i++) begin
      step;
      b4.mem_data_out = (i == 5) ? 8'h3C : 8'hC0 + 8'(i);
      chk($sformatf("rl4.wait%0d", i), {b4.mem_write_enable, b4.mem_read_enable, b4.resp_valid}, 3'b000);
    end
    step;
    b4.mem_data_out = 8'hEE;
    chk("rl4.resp", {b4.resp_valid, b4.resp_err, b4.resp_rdata}, {2'b10, 8'h3C});
    step;
    chk("rl4.after", {b4.resp_valid, b4.req_ready, b4.resp_rdata}, {2'b01, 8'h3C});
    // random traffic with req_valid held high between requests
    hold = 8'h00;
    for (int i = 0; i < NR; i++) begin
      rq[i].w = 1'($urandom_range(0, 1));
      rq[i].s = $urandom_range(0, 3) != 0;
      rq[i].a = 8'($urandom_range(0, 7));
      rq[i].d = 8'($urandom);
      rq[i].t = TRAP && rq[i].w && !rq[i].s;
      rq[i].e = rq[i].w ? hold : rm[rq[i].s][rq[i].a];
      hold = rq[i].e;
      if (rq[i].w && rq[i].s) rm[1][rq[i].a] = rq[i].d;
      rq[i].gap = !rq[i].w ? 4 : rq[i].t ? 2 : 3;
    end
    n = 0; cyc = 0; last = 0; seen = 0;
    b1.req_write = rq[0].w; b1.req_space = rq[0].s; b1.req_addr = rq[0].a; b1.req_wdata = rq[0].d;
    b1.req_valid = 1'b1;
    while (n < NR && cyc < 2000) begin
      step;
      cyc++;
      chk("rand.overlap", b1.mem_write_enable & b1.mem_read_enable, 0);
      if (b1.mem_write_enable || b1.mem_read_enable) begin
        chk("rand.strobe_ready", b1.req_ready, 0);
        chk("rand.dup", seen, 0);
        seen = 1;
        chk("rand.strobe", {b1.mem_write_enable, b1.mem_address, b1.mem_map_select,
            b1.mem_write_enable ? b1.mem_data_in : 8'h00},
            {rq[n].w, rq[n].a, rq[n].s, rq[n].w ? rq[n].d : 8'h00});
      end
      if (b1.resp_valid) begin
        chk("rand.resp_ready", b1.req_ready, 0);
        chk("rand.resp", {b1.resp_err, b1.resp_rdata}, {rq[n].t, rq[n].e});
        chk("rand.strobed", seen, !rq[n].t);
        if (n > 0) chk("rand.gap", cyc - last, rq[n].gap);
        last = cyc;
        seen = 0;
        n++;
        if (n < NR) begin
          b1.req_write = rq[n].w; b1.req_space = rq[n].s; b1.req_addr = rq[n].a; b1.req_wdata = rq[n].d;
        end else b1.req_valid = 1'b0;
      end
    end
    b1.req_valid = 1'b0;
    chk("rand.count", n, NR);
    step;
    // reset with dut4 in WAIT and dut1 in ACCESS, asserted between clock edges
    b4.req_write = 1'b0; b4.req_addr = 8'h44; b4.req_valid = 1'b1;
    step;
    b4.req_valid = 1'b0;
    b1.req_write = 1'b1; b1.req_space = 1'b1; b1.req_addr = 8'h55; b1.req_wdata = 8'h77; b1.req_valid = 1'b1;
    step;
    b1.req_valid = 1'b0;
    chk("arst.pre", {b1.mem_write_enable, b4.req_ready}, 2'b10);
    #2 reset = 1'b0;
    #1;
    chk("arst.b1", {b1.mem_write_enable, b1.mem_read_enable, b1.resp_valid, b1.req_ready}, 4'b0001);
    chk("arst.b4", {b4.mem_write_enable, b4.mem_read_enable, b4.resp_valid, b4.req_ready}, 4'b0001);
    chk("arst.addr", {b1.mem_address, b4.mem_address}, 16'h0);
    step; step;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step;
      chk($sformatf("arst.quiet%0d", i), {b1.resp_valid, b4.resp_valid, b1.req_ready, b4.req_ready}, 4'b0011);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
